z_core_reg_file_param: RTL and testbench

- Parametrised next-generation integer register file for the Z-Core pipeline. Configurable width, depth and read-port count.
- Adds four features:
  - a post-reset clear sequencer, so the storage array needs no per-entry reset and can map to distributed RAM;
  - optional write-first bypass;
  - a pending-write scoreboard for hazard detection;
  - a ready handshake that gates the pipeline until the clear completes.
- Sits between decode (read ports, scoreboard set) and writeback (write port).

---
 rtl/z_core_pkg.sv | 20 ++
 rtl/z_core_reg_scoreboard.sv | 49 ++++
 rtl/z_core_reg_file_param.sv | 120 ++++++++++++
 tb/tb_z_core_reg_file_param.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/z_core_pkg.sv
// Shared types and helpers for the Z-Core integer register file.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package z_core_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/z_core_reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue, cleared at writeback.
// Latency: set/clear visible one cycle after the edge; write-cycle masking is combinational.
// Backpressure: none; flush clears every busy bit on the next edge.
module z_core_reg_scoreboard #(
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = z_core_pkg::clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                wr_vld,
  input  logic [AW-1:0]       wr_addr,
  input  logic                sb_vld,
  input  logic [AW-1:0]       sb_addr,
  input  logic [NREAD*AW-1:0] rs_addr,
  output logic [NREAD-1:0]    rs_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Set is applied after clear so a same-cycle issue to the written register stays busy.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_vld) busy_nxt[wr_addr] = 1'b0;
      if (sb_vld && !(ZERO_REG != 0 && sb_addr == '0)) busy_nxt[sb_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_nxt;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_busy
    logic [AW-1:0] addr;
    logic          wr_hit;
    assign addr       = rs_addr[i*AW +: AW];
    assign wr_hit     = (BYPASS != 0) && wr_vld && (wr_addr == addr);
    assign rs_busy[i] = busy[addr] & ~wr_hit;
  end

endmodule

// File: rtl/z_core_reg_file_param.sv
// Parametrised integer register file with post-reset clear sequencer, bypass and scoreboard.
// Latency: reads combinational, writes on the rising edge; ready NREGS edges after reset/soft_clear.
// Backpressure: ready low gates writes and scoreboard sets; reads return zero until clear completes.
module z_core_reg_file_param
  import z_core_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  soft_clear,
  output logic                  ready,
  input  logic                  wr_en,
  input  logic [AW-1:0]         rd_addr,
  input  logic [XLEN-1:0]       rd_data,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic [NREAD-1:0]      rs_busy,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr
);

  rf_state_t     state;
  rf_state_t     state_nxt;
  logic [AW-1:0] clr_ptr;
  logic [AW-1:0] clr_ptr_nxt;

  logic [XLEN-1:0] mem [NREGS];

  logic wr_vld;
  logic wr_store;
  logic sb_vld;
  logic flush;

  assign ready = (state == READY);

  // A soft_clear cycle drops any write or issue arriving alongside it.
  assign wr_vld   = ready & wr_en & ~soft_clear;
  assign wr_store = wr_vld & ~(ZERO_REG != 0 && rd_addr == '0);
  assign sb_vld   = ready & sb_set & ~soft_clear;
  assign flush    = ~ready | soft_clear;

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      CLEAR: begin
        if (soft_clear) begin
          clr_ptr_nxt = '0;
        end else if (clr_ptr == AW'(NREGS - 1)) begin
          state_nxt   = READY;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + 1'b1;
        end
      end
      READY: begin
        if (soft_clear) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // No reset on the array so it can map onto distributed RAM; the sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (state == CLEAR)  mem[clr_ptr] <= '0;
    else if (wr_store)   mem[rd_addr] <= rd_data;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          zero_hit;
    logic          byp_hit;
    assign addr     = rs_addr[i*AW +: AW];
    assign zero_hit = (ZERO_REG != 0) && (addr == '0);
    assign byp_hit  = (BYPASS != 0) && wr_vld && (rd_addr == addr);
    assign rs_data[i*XLEN +: XLEN] = (!ready || zero_hit) ? '0 :
                                     byp_hit              ? rd_data :
                                                            mem[addr];
  end

  z_core_reg_scoreboard #(
    .NREGS    (NREGS),
    .NREAD    (NREAD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .wr_vld  (wr_vld),
    .wr_addr (rd_addr),
    .sb_vld  (sb_vld),
    .sb_addr (sb_addr),
    .rs_addr (rs_addr),
    .rs_busy (rs_busy)
  );

endmodule

// File: tb/tb_z_core_reg_file_param.sv
// Directed bench for z_core_reg_file_param: default (bypass), no-bypass and 16x3 no-zero configs.
module tb_z_core_reg_file_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Shared stimulus for the BYPASS=1 and BYPASS=0 instances.
  logic        reset_n = 1'b0;
  logic        soft_clear = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data = '0;
  logic [9:0]  rs_addr = '0;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_addr = '0;

  logic        rdy_b, rdy_n;
  logic [63:0] rsd_b, rsd_n;
  logic [1:0]  rsb_b, rsb_n;

  // Stimulus for the NREGS=16, NREAD=3, ZERO_REG=0 instance.
  logic        soft16 = 1'b0;
  logic        wr16 = 1'b0;
  logic [3:0]  wa16 = '0;
  logic [31:0] wd16 = '0;
  logic [11:0] rs16 = '0;
  logic        sb16 = 1'b0;
  logic [3:0]  sa16 = '0;
  logic        rdy16;
  logic [95:0] rsd16;
  logic [2:0]  rsb16;

  z_core_reg_file_param dut (
    .clk(clk), .reset_n(reset_n), .soft_clear(soft_clear), .ready(rdy_b),
    .wr_en(wr_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs_addr(rs_addr), .rs_data(rsd_b), .rs_busy(rsb_b),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  z_core_reg_file_param #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .soft_clear(soft_clear), .ready(rdy_n),
    .wr_en(wr_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs_addr(rs_addr), .rs_data(rsd_n), .rs_busy(rsb_n),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  z_core_reg_file_param #(.NREGS(16), .NREAD(3), .ZERO_REG(0)) dut16 (
    .clk(clk), .reset_n(reset_n), .soft_clear(soft16), .ready(rdy16),
    .wr_en(wr16), .rd_addr(wa16), .rd_data(wd16),
    .rs_addr(rs16), .rs_data(rsd16), .rs_busy(rsb16),
    .sb_set(sb16), .sb_addr(sa16)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        sb;
    logic [4:0]  sa;
    logic [4:0]  a0, a1;
    logic [31:0] bd0, bd1;
    logic        bb0, bb1;
    logic [31:0] nd0, nd1;
    logic        nb0, nb1;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  function automatic vec_t mk(input int wr, input int wa, input logic [31:0] wd,
                              input int sb, input int sa, input int a0, input int a1,
                              input logic [31:0] bd0, input logic [31:0] bd1,
                              input int bb0, input int bb1,
                              input logic [31:0] nd0, input logic [31:0] nd1,
                              input int nb0, input int nb1);
    vec_t v;
    v.wr = 1'(wr); v.wa = 5'(wa); v.wd = wd;
    v.sb = 1'(sb); v.sa = 5'(sa); v.a0 = 5'(a0); v.a1 = 5'(a1);
    v.bd0 = bd0; v.bd1 = bd1; v.bb0 = 1'(bb0); v.bb1 = 1'(bb1);
    v.nd0 = nd0; v.nd1 = nd1; v.nb0 = 1'(nb0); v.nb1 = 1'(nb1);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rdy_edge;
    int rdy16_edge;
    int clr_edge;

    //   wr wa wd            sb sa a0 a1 bd0           bd1           bb bb nd0           nd1           nb nb
    vt[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,        0, 0);
    vt[1]  = mk(1, 0, 32'h12345678, 0, 0, 5, 0, 32'hDEADBEEF, 32'h0,        0, 0, 32'hDEADBEEF, 32'h0,        0, 0);
    vt[2]  = mk(0, 0, 32'h0,        0, 0, 0, 5, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0);
    vt[3]  = mk(1, 9, 32'hA5A5A5A5, 0, 0, 9, 5, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0);
    vt[4]  = mk(0, 0, 32'h0,        0, 0, 9, 9, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0);
    vt[5]  = mk(0, 0, 32'h0,        1, 3, 3, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0, 0);
    vt[6]  = mk(0, 0, 32'h0,        0, 0, 3, 0, 32'h0,        32'h0,        1, 0, 32'h0,        32'h0,        1, 0);
    vt[7]  = mk(1, 3, 32'h1,        0, 0, 3, 3, 32'h1,        32'h1,        0, 0, 32'h0,        32'h0,        1, 1);
    vt[8]  = mk(0, 0, 32'h0,        0, 0, 3, 3, 32'h1,        32'h1,        0, 0, 32'h1,        32'h1,        0, 0);
    vt[9]  = mk(1, 4, 32'h44,       1, 4, 4, 3, 32'h44,       32'h1,        0, 0, 32'h0,        32'h1,        0, 0);
    vt[10] = mk(0, 0, 32'h0,        0, 0, 4, 3, 32'h44,       32'h1,        1, 0, 32'h44,       32'h1,        1, 0);
    vt[11] = mk(0, 0, 32'h0,        1, 0, 0, 4, 32'h0,        32'h44,       0, 1, 32'h0,        32'h44,       0, 1);
    vt[12] = mk(0, 0, 32'h0,        0, 0, 0, 4, 32'h0,        32'h44,       0, 1, 32'h0,        32'h44,       0, 1);
    vt[13] = mk(1, 6, 32'h66,       0, 0, 6, 5, 32'h66,       32'hDEADBEEF, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0);
    vt[14] = mk(0, 0, 32'h0,        1, 6, 6, 5, 32'h66,       32'hDEADBEEF, 0, 0, 32'h66,       32'hDEADBEEF, 0, 0);
    vt[15] = mk(0, 0, 32'h0,        0, 0, 6, 5, 32'h66,       32'hDEADBEEF, 1, 0, 32'h66,       32'hDEADBEEF, 1, 0);

    // Reset state.
    #2;
    chk("rst_ready_b",  32'(rdy_b), 32'h0);
    chk("rst_ready_n",  32'(rdy_n), 32'h0);
    chk("rst_ready_16", 32'(rdy16), 32'h0);
    chk("rst_busy_b",   32'(rsb_b), 32'h0);
    repeat (3) @(posedge clk);
    #1;

    // Clear sequence with writes and issues to x7 that must be ignored.
    wr_en = 1'b1; rd_addr = 5'd7; rd_data = 32'hFFFFFFFF;
    sb_set = 1'b1; sb_addr = 5'd7; rs_addr = {5'd7, 5'd7};
    reset_n = 1'b1;
    rdy_edge = 0;
    rdy16_edge = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (rdy16 && rdy16_edge == 0) rdy16_edge = k;
      if (rdy_b) begin
        rdy_edge = k;
        break;
      end
      chk("clr_rs_data_b", rsd_b[31:0], 32'h0);
      chk("clr_rs_busy_b", 32'(rsb_b), 32'h0);
    end
    wr_en = 1'b0; sb_set = 1'b0;
    chk("clr_ready_edge",    32'(rdy_edge), 32'd32);
    chk("clr_ready_edge_nb", 32'(rdy_n), 32'h1);
    chk("clr16_ready_edge",  32'(rdy16_edge), 32'd16);
    @(negedge clk);
    chk("clr_x7_p0_b",  rsd_b[31:0],  32'h0);
    chk("clr_x7_p1_b",  rsd_b[63:32], 32'h0);
    chk("clr_x7_p0_n",  rsd_n[31:0],  32'h0);
    chk("clr_x7_busy",  32'(rsb_b), 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      wr_en = vt[i].wr; rd_addr = vt[i].wa; rd_data = vt[i].wd;
      sb_set = vt[i].sb; sb_addr = vt[i].sa;
      rs_addr = {vt[i].a1, vt[i].a0};
      @(negedge clk);
      chk($sformatf("v%0d_bd0", i), rsd_b[31:0],  vt[i].bd0);
      chk($sformatf("v%0d_bd1", i), rsd_b[63:32], vt[i].bd1);
      chk($sformatf("v%0d_bb0", i), 32'(rsb_b[0]), 32'(vt[i].bb0));
      chk($sformatf("v%0d_bb1", i), 32'(rsb_b[1]), 32'(vt[i].bb1));
      chk($sformatf("v%0d_nd0", i), rsd_n[31:0],  vt[i].nd0);
      chk($sformatf("v%0d_nd1", i), rsd_n[63:32], vt[i].nd1);
      chk($sformatf("v%0d_nb0", i), 32'(rsb_n[0]), 32'(vt[i].nb0));
      chk($sformatf("v%0d_nb1", i), 32'(rsb_n[1]), 32'(vt[i].nb1));
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0; sb_set = 1'b0;

    // soft_clear mid-program: x4 and x6 busy, x5/x6 hold data.
    soft_clear = 1'b1;
    rs_addr = {5'd6, 5'd5};
    @(negedge clk);
    chk("sc_ready_during_pulse", 32'(rdy_b), 32'h1);
    @(posedge clk);
    #1;
    soft_clear = 1'b0;
    chk("sc_ready_dropped", 32'(rdy_b), 32'h0);
    clr_edge = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (rdy_b) begin
        clr_edge = k;
        break;
      end
    end
    chk("sc_clear_len", 32'(clr_edge), 32'd32);
    @(negedge clk);
    chk("sc_x5_b", rsd_b[31:0],  32'h0);
    chk("sc_x6_b", rsd_b[63:32], 32'h0);
    chk("sc_x5_n", rsd_n[31:0],  32'h0);
    chk("sc_x6_busy_b", 32'(rsb_b), 32'h0);
    @(posedge clk);
    #1;
    rs_addr = {5'd6, 5'd4};
    @(negedge clk);
    chk("sc_x4_x6_busy_b", 32'(rsb_b), 32'h0);
    chk("sc_x4_x6_busy_n", 32'(rsb_n), 32'h0);
    @(posedge clk);
    #1;

    // NREGS=16, NREAD=3, ZERO_REG=0: x0 is an ordinary register.
    wr16 = 1'b1; wa16 = 4'd0; wd16 = 32'hCAFE0000; rs16 = 12'h000;
    @(negedge clk);
    chk("r16_x0_byp_p0", rsd16[31:0],  32'hCAFE0000);
    chk("r16_x0_byp_p2", rsd16[95:64], 32'hCAFE0000);
    @(posedge clk);
    #1;
    wr16 = 1'b0;
    sb16 = 1'b1; sa16 = 4'd0;
    @(negedge clk);
    chk("r16_x0_p0", rsd16[31:0],  32'hCAFE0000);
    chk("r16_x0_p1", rsd16[63:32], 32'hCAFE0000);
    chk("r16_x0_p2", rsd16[95:64], 32'hCAFE0000);
    chk("r16_set_same_cycle", 32'(rsb16), 32'h0);
    @(posedge clk);
    #1;
    sb16 = 1'b0;
    wr16 = 1'b1; wa16 = 4'd15; wd16 = 32'h15151515;
    @(negedge clk);
    chk("r16_x0_busy", 32'(rsb16), 32'h7);
    @(posedge clk);
    #1;
    wr16 = 1'b0;
    rs16 = {4'd15, 4'd0, 4'd15};
    @(negedge clk);
    chk("r16_x15_p0", rsd16[31:0],  32'h15151515);
    chk("r16_x0_p1b", rsd16[63:32], 32'hCAFE0000);
    chk("r16_x15_p2", rsd16[95:64], 32'h15151515);
    chk("r16_busy_mix", 32'(rsb16), 32'h2);
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
